// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: GPIO input conditioning and interrupt source.
// Per pin: 2-flop sync, stable-count debounce, edge detect, pending latch.
//
// Ports:
//   CLK, RSTb  clock, async active-low reset
//   gpio_in    raw asynchronous pad inputs
//   ADDRESS    register select (0 IN, 1 RISE_EN, 2 FALL_EN,
//              3 PENDING (W1C), 4 RAW, 5 LEVEL_MODE if enabled)
//   DATA_IN    write data, WR one-cycle write strobe
//   DATA_OUT   registered read data (1-cycle latency, no strobe)
//   irq        registered level interrupt, OR of pending bits
//
// Optional: define GPIO_IRQ_LEVEL_EN to add LEVEL_MODE at 0x5.
module gpio_irq_ctrl #(
    parameter int N_PINS          = 6,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              RSTb,
    input  logic [N_PINS-1:0] gpio_in,
    input  logic [3:0]        ADDRESS,
    input  logic [15:0]       DATA_IN,
    input  logic              WR,
    output logic [15:0]       DATA_OUT,
    output logic              irq
);

    localparam int CW = (DEBOUNCE_CYCLES > 0)
                      ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [N_PINS-1:0] s1;
    logic [N_PINS-1:0] s2;
    logic [N_PINS-1:0] filtered;
    logic [N_PINS-1:0] prev;
    logic [N_PINS-1:0] rise;
    logic [N_PINS-1:0] fall;
    logic [N_PINS-1:0] rise_en;
    logic [N_PINS-1:0] fall_en;
    logic [N_PINS-1:0] pending;
    logic [N_PINS-1:0] set;
    logic [N_PINS-1:0] clr;
    logic [N_PINS-1:0] wdata;
    logic [15:0]       rdata;
    logic              wr_rise;
    logic              wr_fall;
    logic              wr_pend;
    logic              unused_din;

    assign wdata      = DATA_IN[N_PINS-1:0];
    assign unused_din = ^DATA_IN;

    assign wr_rise = WR && (ADDRESS == 4'h1);
    assign wr_fall = WR && (ADDRESS == 4'h2);
    assign wr_pend = WR && (ADDRESS == 4'h3);

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= gpio_in;
            s2 <= s1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge CLK or negedge RSTb) begin
                if (!RSTb) filtered <= '0;
                else       filtered <= s2;
            end
        end else begin : g_debounce
            logic [CW-1:0] cnt [N_PINS];

            // The counter restarts whenever s2 agrees with the
            // filtered value, so only an unbroken run of
            // DEBOUNCE_CYCLES differing samples flips the output.
            always_ff @(posedge CLK or negedge RSTb) begin
                if (!RSTb) begin
                    filtered <= '0;
                    for (int i = 0; i < N_PINS; i++)
                        cnt[i] <= '0;
                end else begin
                    for (int i = 0; i < N_PINS; i++) begin
                        if (s2[i] == filtered[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] ==
                                     CW'(DEBOUNCE_CYCLES - 1)) begin
                            filtered[i] <= s2[i];
                            cnt[i]      <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) prev <= '0;
        else       prev <= filtered;
    end

    assign rise = filtered & ~prev;
    assign fall = ~filtered & prev;

`ifdef GPIO_IRQ_LEVEL_EN
    logic [N_PINS-1:0] level_mode;
    logic              wr_level;

    assign wr_level = WR && (ADDRESS == 4'h5);

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb)         level_mode <= '0;
        else if (wr_level) level_mode <= wdata;
    end

    // Level pins re-assert pending while high, which also
    // makes W1C ineffective until the pin drops.
    assign set = (rise & rise_en)
               | (fall & fall_en & ~level_mode)
               | (level_mode & rise_en & filtered);
`else
    assign set = (rise & rise_en) | (fall & fall_en);
`endif

    assign clr = wr_pend ? wdata : '0;

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            rise_en <= '0;
            fall_en <= '0;
        end else begin
            if (wr_rise) rise_en <= wdata;
            if (wr_fall) fall_en <= wdata;
        end
    end

    // Set is ORed after the clear so a same-cycle set wins.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) pending <= '0;
        else       pending <= (pending & ~clr) | set;
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) irq <= 1'b0;
        else       irq <= |pending;
    end

    always_comb begin
        rdata = '0;
        case (ADDRESS)
            4'h0: rdata[N_PINS-1:0] = filtered;
            4'h1: rdata[N_PINS-1:0] = rise_en;
            4'h2: rdata[N_PINS-1:0] = fall_en;
            4'h3: rdata[N_PINS-1:0] = pending;
            4'h4: rdata[N_PINS-1:0] = s2;
`ifdef GPIO_IRQ_LEVEL_EN
            4'h5: rdata[N_PINS-1:0] = level_mode;
`endif
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) DATA_OUT <= '0;
        else       DATA_OUT <= rdata;
    end

endmodule
